// File: rtl/banked_soft_memory_if.sv
// Command/completion bus between a load/store master and banked_soft_memory.
interface banked_soft_memory_if;
  logic [3:0]  cCommand;
  logic [31:0] cAddress;
  logic [31:0] cData;
  logic        hReady;
  logic        hSignal;
  logic [31:0] hData;

  modport master (output cCommand, cAddress, cData, input hReady, hSignal, hData);
  modport slave  (input cCommand, cAddress, cData, output hReady, hSignal, hData);
endinterface

// File: rtl/banked_soft_memory.sv
// Word-organised on-chip memory slave with byte/half/word lanes and a command/completion handshake.
// Optional BANKED_SOFT_MEMORY_FAULT_EN: out-of-range or misaligned accesses return 32'hBAD0_ADD5.
`ifndef MemoryInterfaceCommandNOP
`define MemoryInterfaceCommandNOP 4'h0
`define MemoryInterfaceCommandRB  4'h1
`define MemoryInterfaceCommandRS  4'h2
`define MemoryInterfaceCommandRW  4'h3
`define MemoryInterfaceCommandWB  4'h4
`define MemoryInterfaceCommandWS  4'h5
`define MemoryInterfaceCommandWW  4'h6
`define MemoryInterfaceCommandDR  4'h7
`define MemoryInterfaceCommandHAW 4'h8
`endif

module banked_soft_memory #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned LATENCY   = 1,
  parameter logic [31:0] ID_VALUE  = 32'h5054_4D31
) (
  input logic                 clock,
  input logic                 reset,
  banked_soft_memory_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} MemState;

  MemState       state, nextState;
  logic [3:0]    counter;
  logic [3:0]    commandQ;
  logic [31:0]   addressQ, dataQ;
  logic          hReadyQ, hSignalQ;
  logic [31:0]   hDataQ;
  logic          hReadyNext, hSignalNext;
  logic [31:0]   hDataNext;
  logic          accept, execute, fault;
  logic [31:0]   offset, readWord, byteShift, halfShift, writeWord, result;
  logic [3:0]    laneEnable;
  logic [AW-1:0] wordIndex;
  logic [31:0]   memory [DEPTH];

  assign accept    = (state == IDLE) && (bus.cCommand != `MemoryInterfaceCommandNOP);
  assign execute   = (state == BUSY) && (counter == 4'd0);
  // Base is DEPTH*4-aligned, so the offset's low bits are the address's lane bits.
  assign offset    = addressQ - BASE_ADDR;
  assign wordIndex = AW'(offset >> 2);
  assign readWord  = memory[wordIndex];
  assign byteShift = readWord >> {addressQ[1:0], 3'b000};
  assign halfShift = readWord >> {addressQ[1], 4'b0000};

`ifdef BANKED_SOFT_MEMORY_FAULT_EN
  localparam logic [31:0] FAULT_VALUE = 32'hBAD0_ADD5;
  logic isAccess, misaligned, outside;

  assign outside = (offset[31:AW+2] != '0);

  always_comb begin
    isAccess   = 1'b0;
    misaligned = 1'b0;
    case (commandQ)
      `MemoryInterfaceCommandRB, `MemoryInterfaceCommandWB: isAccess = 1'b1;
      `MemoryInterfaceCommandRS, `MemoryInterfaceCommandWS: begin
        isAccess   = 1'b1;
        misaligned = addressQ[0];
      end
      `MemoryInterfaceCommandRW, `MemoryInterfaceCommandWW: begin
        isAccess   = 1'b1;
        misaligned = (addressQ[1:0] != 2'b00);
      end
      default: ;
    endcase
  end

  assign fault = isAccess && (outside || misaligned);
`else
  assign fault = 1'b0;
`endif

  // NOTE: every signal assigned in an always_comb gets a default first, so no path leaves a latch.
  always_comb begin : decode
    result     = 32'h0;
    laneEnable = 4'b0000;
    writeWord  = 32'h0;
    case (commandQ)
      `MemoryInterfaceCommandRB: result = {24'h0, byteShift[7:0]};
      `MemoryInterfaceCommandRS: result = {16'h0, halfShift[15:0]};
      `MemoryInterfaceCommandRW: result = readWord;
      `MemoryInterfaceCommandWB: begin
        laneEnable = 4'b0001 << addressQ[1:0];
        writeWord  = {4{dataQ[7:0]}};
      end
      `MemoryInterfaceCommandWS: begin
        laneEnable = addressQ[1] ? 4'b1100 : 4'b0011;
        writeWord  = {2{dataQ[15:0]}};
      end
      `MemoryInterfaceCommandWW: begin
        laneEnable = 4'b1111;
        writeWord  = dataQ;
      end
      `MemoryInterfaceCommandDR: result = ID_VALUE;
      default: ;  // HAW and undefined encodings complete with zero
    endcase
`ifdef BANKED_SOFT_MEMORY_FAULT_EN
    if (fault) begin
      result     = FAULT_VALUE;
      laneEnable = 4'b0000;
    end
`endif
  end

  always_comb begin : nextStateLogic
    nextState = state;
    case (state)
      IDLE:    if (accept) nextState = BUSY;
      BUSY:    if (execute) nextState = DONE;
      DONE:    if (bus.cCommand == `MemoryInterfaceCommandNOP) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin : outputLogic
    hReadyNext  = (nextState == IDLE);
    hSignalNext = (nextState == DONE);
    hDataNext   = execute ? result : hDataQ;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin : stateRegister
    if (!reset) begin
      state    <= IDLE;
      counter  <= 4'd0;
      commandQ <= `MemoryInterfaceCommandNOP;
      addressQ <= 32'h0;
      dataQ    <= 32'h0;
      hReadyQ  <= 1'b1;
      hSignalQ <= 1'b0;
      hDataQ   <= 32'h0;
    end else begin
      state    <= nextState;
      hReadyQ  <= hReadyNext;
      hSignalQ <= hSignalNext;
      hDataQ   <= hDataNext;
      if (accept) begin
        commandQ <= bus.cCommand;
        addressQ <= bus.cAddress;
        dataQ    <= bus.cData;
        counter  <= 4'(LATENCY - 1);
      end else if (state == BUSY && counter != 4'd0) begin
        counter <= counter - 4'd1;
      end
    end
  end

  // NOTE: the array has no reset; contents survive reset and it stays mappable to RAM.
  // A reset mid-operation forces IDLE, so execute stays low and the pending write is lost.
  always_ff @(posedge clock) begin : memoryWrite
    if (execute) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (laneEnable[lane]) memory[wordIndex][8*lane +: 8] <= writeWord[8*lane +: 8];
      end
    end
  end

  assign bus.hReady  = hReadyQ;
  assign bus.hSignal = hSignalQ;
  assign bus.hData   = hDataQ;
endmodule

// File: tb/tb_banked_soft_memory.sv
// Self-checking bench: three instances (LATENCY 1/3/4) driven by directed and random transactions
// against a byte-addressed reference model.
`ifndef MemoryInterfaceCommandNOP
`define MemoryInterfaceCommandNOP 4'h0
`define MemoryInterfaceCommandRB  4'h1
`define MemoryInterfaceCommandRS  4'h2
`define MemoryInterfaceCommandRW  4'h3
`define MemoryInterfaceCommandWB  4'h4
`define MemoryInterfaceCommandWS  4'h5
`define MemoryInterfaceCommandWW  4'h6
`define MemoryInterfaceCommandDR  4'h7
`define MemoryInterfaceCommandHAW 4'h8
`endif

module tb_banked_soft_memory;
  localparam int          DEPTH       = 64;
  localparam logic [31:0] BASE        = 32'h0000_0000;
  localparam logic [31:0] ID_VALUE    = 32'h5054_4D31;
  localparam logic [31:0] FAULT_VALUE = 32'hBAD0_ADD5;
  localparam int          N           = 3;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic [N-1:0] rstN;
  logic [3:0]   cmdS   [N];
  logic [31:0]  addrS  [N];
  logic [31:0]  dataS  [N];
  logic [N-1:0] readyV, signalV;
  logic [31:0]  hDataV [N];
  logic [7:0]   model  [N][4*DEPTH];
  int asserts = 0;
  int fails   = 0;

  function automatic int latOf(input int i);
    return (i == 0) ? 1 : (i == 1) ? 3 : 4;
  endfunction

  for (genvar g = 0; g < N; g++) begin : inst
    banked_soft_memory_if busIf ();
    assign busIf.cCommand = cmdS[g];
    assign busIf.cAddress = addrS[g];
    assign busIf.cData    = dataS[g];
    assign readyV[g]      = busIf.hReady;
    assign signalV[g]     = busIf.hSignal;
    assign hDataV[g]      = busIf.hData;

    banked_soft_memory #(
      .DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY((g == 0) ? 1 : (g == 1) ? 3 : 4), .ID_VALUE(ID_VALUE)
    ) dut (
      .clock(clock), .reset(rstN[g]), .bus(busIf)
    );
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    asserts++;
    assert (observed === expected) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Reference model: memory as a flat byte array indexed by (address - base) mod size.
  function automatic logic [31:0] modelOp(input int i, input logic [3:0] cmd,
                                          input logic [31:0] addr, input logic [31:0] data);
    int          size = 1;
    bit          isWrite = 1'b0;
    int          b;
    logic [31:0] off;
    logic [31:0] val = 32'h0;
    case (cmd)
      `MemoryInterfaceCommandRB: size = 1;
      `MemoryInterfaceCommandRS: size = 2;
      `MemoryInterfaceCommandRW: size = 4;
      `MemoryInterfaceCommandWB: begin size = 1; isWrite = 1'b1; end
      `MemoryInterfaceCommandWS: begin size = 2; isWrite = 1'b1; end
      `MemoryInterfaceCommandWW: begin size = 4; isWrite = 1'b1; end
      `MemoryInterfaceCommandDR: return ID_VALUE;
      default: return 32'h0;
    endcase
    off = addr - BASE;
`ifdef BANKED_SOFT_MEMORY_FAULT_EN
    if (off >= 4 * DEPTH || addr % size != 0) return FAULT_VALUE;
`endif
    b = int'(off % (4 * DEPTH));
    b = b - (b % size);
    for (int k = 0; k < size; k++) begin
      if (isWrite) model[i][b+k] = data[8*k +: 8];
      else val[8*k +: 8] = model[i][b+k];
    end
    return isWrite ? 32'h0 : val;
  endfunction

  // One full handshake; inputs are scrambled while the block is busy to show they are ignored.
  task automatic transact(input int i, input logic [3:0] cmd, input logic [31:0] addr,
                          input logic [31:0] data, input int hold, input bit dropEarly,
                          output logic [31:0] got);
    logic [31:0] expected;
    int          n = 0;
    string       tag;
    tag      = $sformatf("i%0d cmd%0h @%h", i, cmd, addr);
    expected = modelOp(i, cmd, addr, data);
    @(negedge clock);
    check({tag, " ready"}, {31'b0, readyV[i]}, 32'd1);
    cmdS[i]  = cmd;
    addrS[i] = addr;
    dataS[i] = data;
    @(posedge clock); #1;
    check({tag, " accept"}, {30'b0, readyV[i], signalV[i]}, 32'b00);
    while (!signalV[i] && n < 20) begin
      @(negedge clock);
      cmdS[i]  = dropEarly ? `MemoryInterfaceCommandNOP : 4'($urandom_range(1, 15));
      addrS[i] = $urandom;
      dataS[i] = $urandom;
      @(posedge clock); #1;
      n++;
    end
    check({tag, " latency"}, n, latOf(i));
    check({tag, " data"}, hDataV[i], expected);
    got = hDataV[i];
    for (int h = 0; h < hold; h++) begin
      @(posedge clock); #1;
      check({tag, " held"}, {30'b0, readyV[i], signalV[i]}, 32'b01);
      check({tag, " held data"}, hDataV[i], expected);
    end
    @(negedge clock);
    cmdS[i] = `MemoryInterfaceCommandNOP;
    @(posedge clock); #1;
    check({tag, " release"}, {30'b0, readyV[i], signalV[i]}, 32'b10);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    logic [3:0]  cmd;
    int          r;
    int          hold;
    bit          drop;

    rstN = '1;
    for (int i = 0; i < N; i++) begin
      cmdS[i]  = `MemoryInterfaceCommandNOP;
      addrS[i] = 32'h0;
      dataS[i] = 32'h0;
    end
    #2 rstN = '0;
    repeat (2) @(posedge clock);
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("reset i%0d flags", i), {30'b0, readyV[i], signalV[i]}, 32'b10);
      check($sformatf("reset i%0d data", i), hDataV[i], 32'h0);
    end
    @(negedge clock);
    rstN = '1;

    // Word write/read at two latencies
    transact(0, `MemoryInterfaceCommandWW, 32'h10, 32'hDEADBEEF, 0, 0, got);
    transact(0, `MemoryInterfaceCommandRW, 32'h10, 32'h0, 0, 0, got);
    check("word i0", got, 32'hDEADBEEF);
    transact(2, `MemoryInterfaceCommandWW, 32'h10, 32'hDEADBEEF, 0, 0, got);
    transact(2, `MemoryInterfaceCommandRW, 32'h10, 32'h0, 0, 0, got);
    check("word i2", got, 32'hDEADBEEF);

    // Lane merge
    transact(0, `MemoryInterfaceCommandWW, 32'h20, 32'h11223344, 0, 0, got);
    transact(0, `MemoryInterfaceCommandWB, 32'h22, 32'hFFFF_FFAA, 0, 0, got);
    transact(0, `MemoryInterfaceCommandWS, 32'h20, 32'hFFFF_5566, 0, 0, got);
    transact(0, `MemoryInterfaceCommandRW, 32'h20, 32'h0, 0, 0, got);
    check("merge rw", got, 32'h11AA5566);
    transact(0, `MemoryInterfaceCommandRB, 32'h23, 32'h0, 0, 0, got);
    check("merge rb", got, 32'h00000011);
    transact(0, `MemoryInterfaceCommandRS, 32'h22, 32'h0, 0, 0, got);
    check("merge rs", got, 32'h000011AA);

    // Handshake: held command, then early drop to NOP
    transact(0, `MemoryInterfaceCommandRW, 32'h20, 32'h0, 5, 0, got);
    transact(2, `MemoryInterfaceCommandRW, 32'h10, 32'h0, 0, 1, got);
    check("drop early data", got, 32'hDEADBEEF);

    // Identity, fence and an undefined encoding
    transact(1, `MemoryInterfaceCommandDR, 32'h0, 32'h0, 0, 0, got);
    check("dr", got, ID_VALUE);
    transact(1, `MemoryInterfaceCommandHAW, 32'h0, 32'h0, 0, 0, got);
    check("haw", got, 32'h0);
    transact(1, 4'hC, 32'h0, 32'h0, 0, 0, got);
    check("undefined", got, 32'h0);

    // Misaligned and out-of-range accesses
    transact(0, `MemoryInterfaceCommandWW, 32'h0, 32'h01020304, 0, 0, got);
    transact(0, `MemoryInterfaceCommandRW, 32'h11, 32'h0, 0, 0, got);
`ifdef BANKED_SOFT_MEMORY_FAULT_EN
    check("misaligned rw", got, FAULT_VALUE);
`else
    check("misaligned rw", got, 32'hDEADBEEF);
`endif
    transact(0, `MemoryInterfaceCommandRW, BASE + 4 * DEPTH, 32'h0, 0, 0, got);
`ifdef BANKED_SOFT_MEMORY_FAULT_EN
    check("outside rw", got, FAULT_VALUE);
`else
    check("outside rw", got, 32'h01020304);
`endif
    transact(0, `MemoryInterfaceCommandWW, BASE + 4 * DEPTH, 32'hFFFFFFFF, 0, 0, got);
    transact(0, `MemoryInterfaceCommandRW, 32'h0, 32'h0, 0, 0, got);
`ifdef BANKED_SOFT_MEMORY_FAULT_EN
    check("outside ww dropped", got, 32'h01020304);
`else
    check("outside ww wraps", got, 32'hFFFFFFFF);
`endif

    // Reset mid-BUSY discards the pending write
    transact(1, `MemoryInterfaceCommandWW, 32'h40, 32'hCAFEF00D, 0, 0, got);
    transact(1, `MemoryInterfaceCommandRW, 32'h40, 32'h0, 0, 0, got);
    @(negedge clock);
    cmdS[1]  = `MemoryInterfaceCommandWW;
    addrS[1] = 32'h40;
    dataS[1] = 32'h0BADBEEF;
    @(posedge clock);
    @(negedge clock);
    rstN[1] = 1'b0;
    #1;
    check("reset mid busy flags", {30'b0, readyV[1], signalV[1]}, 32'b10);
    check("reset mid busy data", hDataV[1], 32'h0);
    cmdS[1] = `MemoryInterfaceCommandNOP;
    repeat (2) @(negedge clock);
    rstN[1] = 1'b1;
    transact(1, `MemoryInterfaceCommandRW, 32'h40, 32'h0, 0, 0, got);
    check("write discarded", got, 32'hCAFEF00D);

    // Random traffic per instance after filling every word
    for (int i = 0; i < N; i++) begin
      for (int w = 0; w < DEPTH; w++)
        transact(i, `MemoryInterfaceCommandWW, BASE + 32'(4 * w), $urandom, 0, 0, got);
      for (int t = 0; t < 120; t++) begin
        r    = $urandom_range(0, 9);
        cmd  = (r <= 7) ? 4'(r + 1) : 4'($urandom_range(9, 15));
        drop = ($urandom_range(0, 3) == 0);
        hold = drop ? 0 : $urandom_range(0, 2);
        transact(i, cmd, ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 8 * DEPTH - 1)),
                 $urandom, hold, drop, got);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
